// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode sequencer: fetches an instruction over req/ack and decodes it for one EXEC cycle.
// Drives a one-cycle PC-select code per instruction, with sticky illegal/bus-error flags.
module instr_fetch_ctrl #(
  parameter int unsigned AW      = 6,
  parameter int unsigned IW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          zero_flag,
  input  logic          neg_flag,
  output logic [1:0]    ps,
  output logic [3:0]    da,
  output logic [3:0]    aa,
  output logic [3:0]    ba,
  output logic [3:0]    opcode,
  output logic          instr_valid,
  output logic          illegal,
  output logic          bus_err,
  output logic          halted
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StStart, StFetch, StExec, StHalt} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;

  assign opcode = ir_q[15:12];
  assign da     = ir_q[11:8];
  assign aa     = ir_q[7:4];
  assign ba     = ir_q[3:0];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        // An ack on the timeout edge still wins over the bus error.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = StExec;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d     = CW'(TIMEOUT);
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        if ((opcode >= 4'hB) && (opcode <= 4'hE)) illegal_d = 1'b1;
        state_d = (opcode == 4'hF) ? StHalt : StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StStart;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = imem_req ? pc : '0;
    instr_valid = (state_q == StExec);
    halted      = (state_q == StHalt);
    illegal     = illegal_q;
    bus_err     = bus_err_q;
    ps          = 2'b00;
    // Branch selects follow the live flags during the single EXEC cycle.
    if (instr_valid) begin
      case (opcode)
        4'h8:    ps = zero_flag ? 2'b10 : 2'b01;
        4'h9:    ps = neg_flag ? 2'b10 : 2'b01;
        4'hA:    ps = 2'b11;
        4'hF:    ps = 2'b00;
        default: ps = 2'b01;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized self-checking bench for instr_fetch_ctrl against a transaction-level model.
module tb_instr_fetch_ctrl;

  localparam int unsigned AW      = 6;
  localparam int unsigned IW      = 16;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          zero_flag, neg_flag;
  logic [1:0]    ps;
  logic [3:0]    da, aa, ba, opcode;
  logic          instr_valid, illegal, bus_err, halted;

  instr_fetch_ctrl #(.AW(AW), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .ps(ps), .da(da), .aa(aa), .ba(ba), .opcode(opcode), .instr_valid(instr_valid),
    .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: last fetched word and the sticky flags.
  logic [15:0] ir_m;
  bit          ill_m, berr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ps_of(input logic [15:0] w, input bit z, input bit n);
    case (w[15:12])
      4'h8:    return z ? 2'd2 : 2'd1;
      4'h9:    return n ? 2'd2 : 2'd1;
      4'hA:    return 2'd3;
      4'hF:    return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  task automatic check_cycle(input string tag, input bit req, input logic [AW-1:0] addr,
                             input logic [1:0] ps_e, input bit iv, input bit hlt);
    chk({tag, ".req"}, 32'(imem_req), 32'(req));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, ".ps"}, 32'(ps), 32'(ps_e));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(iv));
    chk({tag, ".halted"}, 32'(halted), 32'(hlt));
    chk({tag, ".opcode"}, 32'(opcode), 32'(ir_m[15:12]));
    chk({tag, ".da"}, 32'(da), 32'(ir_m[11:8]));
    chk({tag, ".aa"}, 32'(aa), 32'(ir_m[7:4]));
    chk({tag, ".ba"}, 32'(ba), 32'(ir_m[3:0]));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill_m));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(berr_m));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Entered at the sample point of the first FETCH cycle of an instruction.
  task automatic run_instr(input logic [15:0] w, input int waits, input bit z, input bit n);
    logic [1:0] p;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      check_cycle("fetch", 1'b1, pc, 2'd0, 1'b0, 1'b0);
      if (k == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = w;
        zero_flag  = z;
        neg_flag   = n;
        next_cycle();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        ir_m       = w;
        p          = ps_of(w, z, n);
        check_cycle("exec", 1'b0, '0, p, 1'b1, 1'b0);
        if (w[15:12] >= 4'hB && w[15:12] <= 4'hE) ill_m = 1'b1;
        case (p)
          2'd1:    pc = pc + AW'(1);
          2'd2:    pc = pc + AW'(1) + AW'(w[3:0]);
          2'd3:    pc = AW'(w[7:4]);
          default: pc = pc;
        endcase
        // Acks and flags outside FETCH must have no effect.
        imem_ack  = 1'($urandom);
        zero_flag = 1'($urandom);
        neg_flag  = 1'($urandom);
        next_cycle();
        imem_ack = 1'b0;
        return;
      end
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      zero_flag  = 1'($urandom);
      neg_flag   = 1'($urandom);
      next_cycle();
    end
    berr_m = 1'b1;
  endtask

  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_cycle("halt", 1'b0, '0, 2'd0, 1'b0, 1'b1);
      imem_ack   = 1'($urandom);
      imem_rdata = 16'($urandom);
      next_cycle();
    end
    imem_ack = 1'b0;
  endtask

  // Async reset mid-cycle, then release into START; ends at the first FETCH sample point.
  task automatic do_reset(input bit ack_during);
    #2;
    reset = 1'b1;
    #1;
    ir_m   = '0;
    ill_m  = 1'b0;
    berr_m = 1'b0;
    pc     = '0;
    check_cycle("rst_now", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    imem_ack   = ack_during;
    imem_rdata = 16'h5555;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    check_cycle("start", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    next_cycle();
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    reset      = 1'b1;
    pc         = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    zero_flag  = 1'b0;
    neg_flag   = 1'b0;
    ir_m       = '0;
    ill_m      = 1'b0;
    berr_m     = 1'b0;

    repeat (2) next_cycle();
    check_cycle("reset", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    check_cycle("start", 1'b0, '0, 2'd0, 1'b0, 1'b0);
    next_cycle();

    run_instr(16'h1234, 0, 1'b0, 1'b0);
    run_instr(16'h0567, 3, 1'b0, 1'b0);
    run_instr(16'h8012, 0, 1'b1, 1'b0);
    run_instr(16'h8012, 1, 1'b0, 1'b1);
    run_instr(16'h9000, 0, 1'b0, 1'b1);
    run_instr(16'h9000, 2, 1'b1, 1'b0);
    run_instr(16'hA000, 0, 1'b0, 1'b0);
    run_instr(16'hC000, 0, 1'b0, 1'b0);
    run_instr(16'h2345, int'(TIMEOUT) - 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      run_instr(w, ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) - 1 : int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
    end

    run_instr(16'hF000, 0, 1'b0, 1'b0);
    check_halt(20);

    do_reset(1'b1);
    run_instr(16'h1234, int'(TIMEOUT), 1'b0, 1'b0);
    check_halt(20);

    // Reset during the second wait cycle of a fetch; the pending ack must be dropped.
    do_reset(1'b0);
    check_cycle("fetch0", 1'b1, pc, 2'd0, 1'b0, 1'b0);
    next_cycle();
    check_cycle("fetch1", 1'b1, pc, 2'd0, 1'b0, 1'b0);
    do_reset(1'b1);
    run_instr(16'h1234, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      run_instr(w, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch and decode sequencer that sits on the consumer side of the program counter.
- Drives the current PC to instruction memory over a req/ack handshake and captures the returned 16-bit instruction.
- Decodes the instruction into DA/AA/BA register fields and a 2-bit PS code.
- PS is non-zero for exactly one cycle per instruction, so the PC advances once per fetched instruction.

Parameters:
- AW, 6, PC / instruction-memory address width.
- IW, 16, instruction width; fixed field layout below requires 16.
- TIMEOUT, 15, max cycles imem_req may stay high without imem_ack before bus error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc  in  AW  current program counter (changes on clk negedge).
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  AW  equals pc while imem_req=1, else 0.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  IW  instruction word.
- zero_flag  in  1  ALU zero status.
- neg_flag  in  1  ALU negative status.
- ps  out  2  PC select: 00 hold, 01 +1, 10 +1+offset, 11 load A.
- da, aa, ba  out  4 each  destination / source-A / source-B register fields.
- opcode  out  4  IR[15:12].
- instr_valid  out  1  high for the single EXEC cycle.
- illegal  out  1  sticky; reserved opcode was executed.
- bus_err  out  1  sticky; fetch timed out.
- halted  out  1  in HALT state.

Behaviour:
- IR field layout: opcode = IR[15:12], da = IR[11:8], aa = IR[7:4], ba = IR[3:0].
- States: START (reset state), FETCH, EXEC, HALT. All outputs are Moore, decoded from the state register and IR, except ps in EXEC (see below).
- Reset values:
  - state = START, IR = 0, timeout counter = 0.
  - ps = 00, imem_req = 0, imem_addr = 0.
  - da/aa/ba/opcode = 0.
  - instr_valid = illegal = bus_err = halted = 0.
- START: outputs idle. The next posedge moves to FETCH unconditionally.
- FETCH:
  - imem_req = 1, imem_addr = pc, ps = 00.
  - Posedge with imem_ack = 1: IR <= imem_rdata, counter cleared, go to EXEC.
  - Posedge with imem_ack = 0: counter increments. When the counter reaches TIMEOUT, set bus_err and go to HALT.
- EXEC (exactly one cycle):
  - instr_valid = 1; da/aa/ba/opcode driven from IR.
  - ps is combinational from opcode and the live flags:
    - 0x0–0x7: 01.
    - 0x8 BRZ: 10 if zero_flag, else 01.
    - 0x9 BRN: 10 if neg_flag, else 01.
    - 0xA JMP: 11.
    - 0xF HALT: 00.
    - 0xB–0xE reserved: 01, and illegal is set at the posedge.
  - The PC captures ps on the negedge inside this cycle.
  - Next posedge: go to HALT if opcode = 0xF, else to FETCH.
- HALT: ps = 00, halted = 1, imem_req = 0. Leaves only via reset.
- Outside EXEC, da/aa/ba/opcode hold their last IR values and ps = 00.
- Throughput: minimum 2 cycles per instruction with zero-wait memory (ack in the first FETCH cycle). Each memory wait cycle adds one.
- imem_ack outside FETCH is ignored; IR is not modified.
- imem_rdata is sampled only on a posedge where state = FETCH and imem_ack = 1.
- Ack on the same posedge the timeout counter reaches TIMEOUT: the ack wins; no bus_err, go to EXEC.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to START with all outputs at reset values. An ack arriving during reset, or in the START cycle, is ignored.
- illegal and bus_err clear only on reset.

Test Plan:
- Reset release, memory acks immediately, rdata = 0x1234: cycle 1 START; cycle 2 FETCH with imem_addr = pc = 0; cycle 3 EXEC with ps = 01, da = 2, aa = 3, ba = 4, instr_valid = 1; cycle 4 FETCH with imem_addr = 1.
- Ack delayed 3 cycles: imem_req stays high 4 cycles, ps = 00 throughout, PC unchanged; then a single EXEC with ps = 01.
- BRZ 0x8012 with zero_flag = 1 -> ps = 10, aa = 1, ba = 2. Same word with zero_flag = 0 -> ps = 01. BRN 0x9000 with neg_flag = 1 -> ps = 10.
- JMP 0xA000 -> ps = 11 for one cycle. HALT 0xF000 -> ps = 00, halted = 1, no further imem_req for 20 cycles.
- Reserved opcode 0xC000 -> ps = 01 and illegal stays 1 on subsequent fetches. Ack withheld -> bus_err = 1 and halted = 1 after exactly TIMEOUT = 15 FETCH posedges.
- Reset pulse during the second FETCH wait cycle -> imem_req falls immediately; the ack is ignored; the sequence restarts from START.
